// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_pkg
//  Description : Shared widths, enable polarities, FSM state encoding and a
//                small index-width helper for the multi-port register file.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_mp_pkg;

    localparam int RDATA_WIDTH = 32;
    localparam int RADDR_WIDTH = 5;
    localparam int RNUM        = 32;
    localparam int ZERO_REG    = 0;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    // Clear sequencer states
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Width needed to index n items; never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arb
//  Description : Write-port arbitration for one register address. Reports
//                whether any enabled port targets ADDR, which port wins
//                (highest index) and whether two or more ports collide.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int NUM_WR = 1,
    parameter int ADDR_W = RADDR_WIDTH,
    parameter int ADDR   = 1,
    parameter int IDX_W  = idx_width(NUM_WR)
) (
    input  logic [NUM_WR-1:0]        en,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    output logic                     hit,
    output logic [IDX_W-1:0]         win,
    output logic                     conflict
);

    // Scan ports low to high so the last match (highest index) wins
    always_comb begin
        hit      = 1'b0;
        win      = '0;
        conflict = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (en[k] && (waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(ADDR))) begin
                conflict = conflict | hit;
                hit      = 1'b1;
                win      = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port integer register file with write-to-read bypass,
//                highest-port-wins write arbitration with conflict pulse,
//                post-reset clear sequencer with ready flag and a registered
//                debug read port. Register 0 always reads as zero.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W         = RDATA_WIDTH,
    parameter int ADDR_W         = RADDR_WIDTH,
    parameter int NREGS          = RNUM,
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wdata_i,
    input  logic [NUM_RD-1:0]        re_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic                     ready_o,
    output logic                     wr_conflict_o,
    input  logic [ADDR_W-1:0]        dbg_raddr_i,
    output logic [DATA_W-1:0]        dbg_rdata_o
);

    localparam int              c_idx_w  = idx_width(NUM_WR);
    localparam int              c_clr_w  = idx_width(NREGS);
    localparam logic [ADDR_W:0] c_nregs  = (ADDR_W+1)'(NREGS);
    localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(ZERO_REG);

    rf_state_e           r_state;
    logic [c_clr_w-1:0]  r_clr_idx;
    logic                r_ready;
    logic                r_conflict;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic [DATA_W-1:0]   r_regs [NREGS];

    logic [NUM_WR-1:0]   w_wen;
    logic [DATA_W-1:0]   w_wdata [NUM_WR];
    logic [NREGS-1:0]    w_hit;
    logic [c_idx_w-1:0]  w_win [NREGS];
    logic [NREGS-1:0]    w_conf;

    // Writes are only honoured once the file is usable
    generate
        for (genvar k = 0; k < NUM_WR; k++) begin : g_wport
            assign w_wen[k]   = r_ready && (we_i[k] == WRITE_ENABLE);
            assign w_wdata[k] = wdata_i[k*DATA_W +: DATA_W];
        end
    endgenerate

    // One arbiter per writable register; the zero register never matches
    generate
        for (genvar r = 0; r < NREGS; r++) begin : g_reg
            if (r == ZERO_REG) begin : g_zero
                assign w_hit[r]  = 1'b0;
                assign w_win[r]  = '0;
                assign w_conf[r] = 1'b0;
            end else begin : g_arb
                regfile_wr_arb #(
                    .NUM_WR (NUM_WR),
                    .ADDR_W (ADDR_W),
                    .ADDR   (r),
                    .IDX_W  (c_idx_w)
                ) u_arb (
                    .en       (w_wen),
                    .waddr    (waddr_i),
                    .hit      (w_hit[r]),
                    .win      (w_win[r]),
                    .conflict (w_conf[r])
                );
            end
        end
    endgenerate

    // Clear sequencer: walk every register once, then declare the file ready
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_READY;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    if (r_clr_idx == c_clr_w'(NREGS - 1)) begin
                        r_state <= RF_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                RF_READY: r_ready <= 1'b1;
                default:  r_state <= RF_READY;
            endcase
        end
    end

    // Storage update: clear sweep while clearing, otherwise arbitrated writes
    always_ff @(posedge clk_i) begin
        if (!rst_i && (r_state == RF_CLEAR)) begin
            r_regs[r_clr_idx] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_hit[r]) begin
                    r_regs[r] <= w_wdata[w_win[r]];
                end
            end
        end
    end

    // Conflict pulse and debug read, both one cycle behind their inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_conflict  <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_conflict <= |w_conf;
            if ((dbg_raddr_i == c_zero) || ({1'b0, dbg_raddr_i} >= c_nregs)) begin
                r_dbg_rdata <= '0;
            end else begin
                r_dbg_rdata <= r_regs[dbg_raddr_i];
            end
        end
    end

    // Read ports: gating first, then same-cycle forwarding, then storage
    generate
        for (genvar j = 0; j < NUM_RD; j++) begin : g_rport
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;

            assign w_ra = raddr_i[j*ADDR_W +: ADDR_W];

            // Combinational read mux for port j
            always_comb begin
                w_rd = '0;
                if ((w_ra == c_zero) || (re_i[j] != READ_ENABLE) || !r_ready ||
                    ({1'b0, w_ra} >= c_nregs)) begin
                    w_rd = '0;
                end else if ((BYPASS != 0) && w_hit[w_ra]) begin
                    w_rd = w_wdata[w_win[w_ra]];
                end else begin
                    w_rd = r_regs[w_ra];
                end
            end

            assign rdata_o[j*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

    assign ready_o       = r_ready;
    assign wr_conflict_o = r_conflict;
    assign dbg_rdata_o   = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Main instance has two
//                write ports with bypass and clear-on-reset; a second
//                instance has one write port, no bypass and no clear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: NUM_RD=2, NUM_WR=2, BYPASS=1, CLEAR_ON_RESET=1
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        ready;
    logic        conf;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    // Second instance: NUM_RD=1, NUM_WR=1, BYPASS=0, CLEAR_ON_RESET=0
    logic        nb_rst;
    logic        nb_we;
    logic [4:0]  nb_waddr;
    logic [31:0] nb_wdata;
    logic        nb_re;
    logic [4:0]  nb_raddr;
    logic [31:0] nb_rdata;
    logic        nb_ready;
    logic        nb_conf;
    logic [4:0]  nb_dbg_raddr;
    logic [31:0] nb_dbg_rdata;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NREGS(32), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(1), .CLEAR_ON_RESET(1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .ready_o(ready),
        .wr_conflict_o(conf), .dbg_raddr_i(dbg_raddr), .dbg_rdata_o(dbg_rdata)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NREGS(32), .NUM_RD(1), .NUM_WR(1),
        .BYPASS(0), .CLEAR_ON_RESET(0)
    ) u_nb (
        .clk_i(clk), .rst_i(nb_rst), .we_i(nb_we), .waddr_i(nb_waddr), .wdata_i(nb_wdata),
        .re_i(nb_re), .raddr_i(nb_raddr), .rdata_o(nb_rdata), .ready_o(nb_ready),
        .wr_conflict_o(nb_conf), .dbg_raddr_i(nb_dbg_raddr), .dbg_rdata_o(nb_dbg_rdata)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [31:0] e0, e1;
        logic        ec;
    } exp_t;

    localparam int NV = 11;
    vec_t        vecs [NV];
    exp_t        sbq [$];
    logic [31:0] model [32];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count edges after reset release until the main ready rises (bounded)
    task automatic count_ready(output int cyc);
        int i;
        i = 0;
        while (!ready && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        cyc = ready ? i : -1;
    endtask

    task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        dbg_raddr = a;
        @(posedge clk); #1;
        d = dbg_rdata;
    endtask

    task automatic dbg_sweep(input string tag);
        logic [31:0] d;
        for (int r = 0; r < 32; r++) begin
            dbg_read(5'(r), d);
            check($sformatf("%s dbg x%0d", tag, r), d, model[r]);
        end
    endtask

    task automatic idle_main();
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] d;
        exp_t        e;

        vecs[0]  = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b01, 5'd5,  5'd5,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       2'b11, 5'd7,  5'd7,  32'h22,       32'h22,       1'b1};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 1'b0};
        vecs[4]  = '{2'b11, 5'd0,  5'd0,  32'hFFFF,     32'hFFFF,     2'b11, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[5]  = '{2'b11, 5'd9,  5'd10, 32'h1234,     32'h5678,     2'b11, 5'd9,  5'd10, 32'h1234,     32'h5678,     1'b0};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b10, 5'd9,  5'd10, 32'h0,        32'h5678,     1'b0};
        vecs[7]  = '{2'b11, 5'd12, 5'd5,  32'hAAAA,     32'hCAFE0001, 2'b11, 5'd5,  5'd12, 32'hCAFE0001, 32'hAAAA,     1'b0};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 5'd12, 5'd5,  32'hAAAA,     32'hCAFE0001, 1'b0};
        vecs[9]  = '{2'b01, 5'd31, 5'd0,  32'h31,       32'h0,        2'b00, 5'd31, 5'd31, 32'h0,        32'h0,        1'b0};
        vecs[10] = '{2'b10, 5'd9,  5'd9,  32'h99,       32'h9A,       2'b11, 5'd9,  5'd31, 32'h9A,       32'h31,       1'b0};

        for (int r = 0; r < 32; r++) model[r] = '0;

        rst = 1'b1; nb_rst = 1'b1;
        idle_main();
        dbg_raddr = '0;
        nb_we = 1'b0; nb_waddr = '0; nb_wdata = '0; nb_re = 1'b0; nb_raddr = '0; nb_dbg_raddr = '0;

        // Reset held three cycles; outputs at reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(ready), 32'd0);
        check("reset conflict", 32'(conf), 32'd0);
        check("reset dbg", dbg_rdata, 32'd0);
        check("reset nb ready", 32'(nb_ready), 32'd0);

        // Clear after reset: ready rises on the 32nd edge after release
        @(negedge clk);
        rst = 1'b0;
        count_ready(cyc);
        check("clear latency", 32'(cyc), 32'd32);
        dbg_sweep("clear1");

        // Table-driven vectors with scoreboard of expected read data
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            we    = vecs[i].we;
            waddr = {vecs[i].wa1, vecs[i].wa0};
            wdata = {vecs[i].wd1, vecs[i].wd0};
            re    = vecs[i].re;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            sbq.push_back('{vecs[i].e0, vecs[i].e1, vecs[i].ec});
            if (vecs[i].we[0] && vecs[i].wa0 != 5'd0) model[vecs[i].wa0] = vecs[i].wd0;
            if (vecs[i].we[1] && vecs[i].wa1 != 5'd0) model[vecs[i].wa1] = vecs[i].wd1;
            #2;
            e = sbq.pop_front();
            check($sformatf("v%0d rdata0", i), rdata[31:0], e.e0);
            check($sformatf("v%0d rdata1", i), rdata[63:32], e.e1);
            @(posedge clk); #1;
            check($sformatf("v%0d conflict", i), 32'(conf), 32'(e.ec));
        end
        @(negedge clk);
        idle_main();
        dbg_sweep("written");

        // Non-bypass instance: ready one edge after release, old value on same-cycle read
        @(negedge clk);
        nb_rst = 1'b0;
        @(posedge clk); #1;
        check("nb ready", 32'(nb_ready), 32'd1);
        @(negedge clk);
        nb_we = 1'b1; nb_waddr = 5'd5; nb_wdata = 32'h0;
        @(negedge clk);
        nb_wdata = 32'hDEADBEEF; nb_re = 1'b1; nb_raddr = 5'd5;
        #2;
        check("nb no-bypass", nb_rdata, 32'h0);
        @(negedge clk);
        nb_we = 1'b0;
        #2;
        check("nb stored", nb_rdata, 32'hDEADBEEF);
        // Write while not ready is dropped, reads return 0
        @(negedge clk);
        nb_rst = 1'b1;
        @(negedge clk);
        nb_rst = 1'b0;
        nb_we = 1'b1; nb_waddr = 5'd5; nb_wdata = 32'h1111;
        #2;
        check("nb gated read", nb_rdata, 32'h0);
        @(posedge clk); #1;
        check("nb ready again", 32'(nb_ready), 32'd1);
        @(negedge clk);
        nb_we = 1'b0;
        #2;
        check("nb dropped write", nb_rdata, 32'hDEADBEEF);
        @(negedge clk);
        nb_dbg_raddr = 5'd5;
        @(posedge clk); #1;
        check("nb dbg", nb_dbg_rdata, 32'hDEADBEEF);

        // Reset mid-clear on main instance, with gated traffic during the clear
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h66, 32'h55};
        re = 2'b11; raddr = {5'd7, 5'd5};
        #2;
        check("gated rdata0", rdata[31:0], 32'h0);
        check("gated rdata1", rdata[63:32], 32'h0);
        @(posedge clk); #1;
        check("gated conflict", 32'(conf), 32'd0);
        @(negedge clk);
        idle_main();
        repeat (9) @(posedge clk);
        #1;
        check("mid-clear ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_ready(cyc);
        check("restart latency", 32'(cyc), 32'd32);
        for (int r = 0; r < 32; r++) model[r] = '0;
        dbg_sweep("clear2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
